// File: rtl/count_bounce_ctrl_pkg.sv
// rtl/count_bounce_ctrl_pkg.sv - shared types and constants for the bounce controller
// Purpose: state encoding, counter mode encoding and default widths shared by
//          the controller, its interface and the bounce counter.
// Ports:   none (package).
package count_bounce_ctrl_pkg;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_BCNT_W = 8;

  // Level on the counter's mode input.
  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DN = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    RUN_UP = 2'd2,
    RUN_DN = 2'd3
  } state_t;

endpackage

// File: rtl/count_bounce_ctrl_if.sv
// rtl/count_bounce_ctrl_if.sv - control/status bundle between a host and the bounce controller
// Purpose: groups the start/stop request, limits, counter feedback and status.
// Ports (slave view, i.e. the controller):
//   in : start, stop, lo_lim, hi_lim, count_in
//   out: mode, active, at_limit, bounce_cnt, err
interface count_bounce_ctrl_if #(
  parameter int WIDTH  = count_bounce_ctrl_pkg::DEF_WIDTH,
  parameter int BCNT_W = count_bounce_ctrl_pkg::DEF_BCNT_W
);

  logic              start;
  logic              stop;
  logic [WIDTH-1:0]  lo_lim;
  logic [WIDTH-1:0]  hi_lim;
  logic [WIDTH-1:0]  count_in;
  logic              mode;
  logic              active;
  logic              at_limit;
  logic [BCNT_W-1:0] bounce_cnt;
  logic              err;

  modport master (
    output start, stop, lo_lim, hi_lim, count_in,
    input  mode, active, at_limit, bounce_cnt, err
  );

  modport slave (
    input  start, stop, lo_lim, hi_lim, count_in,
    output mode, active, at_limit, bounce_cnt, err
  );

endinterface

// File: rtl/count_bounce_ctrl_sat_counter.sv
// rtl/count_bounce_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts inc pulses and sticks at all-ones.
// Ports:
//   clk   in  clock
//   clr   in  synchronous active-low reset
//   clear in  synchronous clear (below reset, above inc)
//   inc   in  increment request
//   q     out count value
module count_bounce_ctrl_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/count_bounce_ctrl.sv
// rtl/count_bounce_ctrl.sv - steers an up/down counter to bounce between two limits
// Purpose: samples the counter value, drives its mode so it bounces between the
//          latched limits, pulses at_limit on each reversal, counts reversals
//          and flags rejected starts or an out-of-range count.
// Ports:
//   clk  in  clock
//   clr  in  synchronous active-low reset (shared with the counter)
//   bus  slave view of count_bounce_ctrl_if (start/stop/limits/count_in in,
//        mode/active/at_limit/bounce_cnt/err out, all registered)
module count_bounce_ctrl
  import count_bounce_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BCNT_W = DEF_BCNT_W
) (
  input  logic                 clk,
  input  logic                 clr,
  count_bounce_ctrl_if.slave   bus
);

  state_t           state, state_nxt;
  logic             mode_q, mode_nxt;
  logic             active_q, at_limit_q, at_limit_nxt, err_q, err_nxt;
  logic [WIDTH-1:0] lo_q, lo_nxt, hi_q, hi_nxt;
  logic             bcnt_clear, bcnt_inc;
  logic             out_of_range;

  // Only meaningful in RUN states, where lo_q < hi_q is guaranteed.
  assign out_of_range = (bus.count_in < lo_q) || (bus.count_in > hi_q);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= IDLE;
      mode_q     <= MODE_UP;
      active_q   <= 1'b0;
      at_limit_q <= 1'b0;
      err_q      <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      state      <= state_nxt;
      mode_q     <= mode_nxt;
      active_q   <= (state_nxt != IDLE);
      at_limit_q <= at_limit_nxt;
      err_q      <= err_nxt;
      lo_q       <= lo_nxt;
      hi_q       <= hi_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode_q;
    at_limit_nxt = 1'b0;
    err_nxt      = 1'b0;
    lo_nxt       = lo_q;
    hi_nxt       = hi_q;
    bcnt_clear   = 1'b0;
    bcnt_inc     = 1'b0;

    if (bus.stop) begin
      state_nxt = IDLE;
      mode_nxt  = MODE_UP;
    end else begin
      unique case (state)
        IDLE: begin
          mode_nxt = MODE_UP;
          if (bus.start) begin
            if (bus.lo_lim < bus.hi_lim) begin
              lo_nxt     = bus.lo_lim;
              hi_nxt     = bus.hi_lim;
              bcnt_clear = 1'b1;
              // Compare against the incoming limit: lo_q is not loaded yet.
              state_nxt  = (bus.count_in == bus.lo_lim) ? RUN_UP : SEEK;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        SEEK: begin
          mode_nxt = MODE_UP;
          if (bus.count_in == lo_q) state_nxt = RUN_UP;
        end
        RUN_UP: begin
          if (out_of_range) begin
            err_nxt   = 1'b1;
            mode_nxt  = MODE_UP;
            state_nxt = SEEK;
          end else if (bus.count_in == hi_q) begin
            mode_nxt     = MODE_DN;
            state_nxt    = RUN_DN;
            at_limit_nxt = 1'b1;
            bcnt_inc     = 1'b1;
          end else begin
            mode_nxt = MODE_UP;
          end
        end
        RUN_DN: begin
          if (out_of_range) begin
            err_nxt   = 1'b1;
            mode_nxt  = MODE_UP;
            state_nxt = SEEK;
          end else if (bus.count_in == lo_q) begin
            mode_nxt     = MODE_UP;
            state_nxt    = RUN_UP;
            at_limit_nxt = 1'b1;
            bcnt_inc     = 1'b1;
          end else begin
            mode_nxt = MODE_DN;
          end
        end
        default: begin
          state_nxt = IDLE;
          mode_nxt  = MODE_UP;
        end
      endcase
    end
  end

  count_bounce_ctrl_sat_counter #(.W(BCNT_W)) u_bcnt (
    .clk   (clk),
    .clr   (clr),
    .clear (bcnt_clear),
    .inc   (bcnt_inc),
    .q     (bus.bounce_cnt)
  );

  assign bus.mode     = mode_q;
  assign bus.active   = active_q;
  assign bus.at_limit = at_limit_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_count_bounce_ctrl.sv
// tb/tb_count_bounce_ctrl.sv - directed scoreboard bench for count_bounce_ctrl
module tb_count_bounce_ctrl;

  typedef struct packed {
    logic       mode;
    logic       active;
    logic       at_limit;
    logic       err;
    logic [1:0] bc;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] cnt = 3'd0;
  int         checks = 0;
  int         failures = 0;
  int         step_no = 0;
  exp_t       sb[$];

  count_bounce_ctrl_if #(.WIDTH(3), .BCNT_W(2)) bus ();

  count_bounce_ctrl #(.WIDTH(3), .BCNT_W(2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic m, input logic a, input logic t,
                              input logic e, input logic [1:0] b);
    exp_t r;
    r.mode = m; r.active = a; r.at_limit = t; r.err = e; r.bc = b;
    return r;
  endfunction

  // One clock: drive inputs, queue the expected registered outputs, then pop
  // and compare after the edge. The counter model then takes its step using
  // the mode registered at this edge, so the next sample reflects it.
  task automatic cyc(input logic c, input logic s, input logic p, input exp_t e);
    exp_t x;
    clr          = c;
    bus.start    = s;
    bus.stop     = p;
    bus.count_in = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    x = sb.pop_front();
    checks++;
    assert (bus.mode === x.mode) else begin
      failures++;
      $error("FAIL step%0d mode got=%0b exp=%0b", step_no, bus.mode, x.mode);
    end
    checks++;
    assert (bus.active === x.active) else begin
      failures++;
      $error("FAIL step%0d active got=%0b exp=%0b", step_no, bus.active, x.active);
    end
    checks++;
    assert (bus.at_limit === x.at_limit) else begin
      failures++;
      $error("FAIL step%0d at_limit got=%0b exp=%0b", step_no, bus.at_limit, x.at_limit);
    end
    checks++;
    assert (bus.err === x.err) else begin
      failures++;
      $error("FAIL step%0d err got=%0b exp=%0b", step_no, bus.err, x.err);
    end
    checks++;
    assert (bus.bounce_cnt === x.bc) else begin
      failures++;
      $error("FAIL step%0d bounce_cnt got=%0d exp=%0d", step_no, bus.bounce_cnt, x.bc);
    end
    if (!c) cnt = 3'd0;
    else if (bus.mode) cnt = cnt - 3'd1;
    else cnt = cnt + 3'd1;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.lo_lim = 3'd0; bus.hi_lim = 3'd0; bus.count_in = 3'd0;

    // reset, then seek to lo=2 and bounce up to 5
    cyc(0, 0, 0, ex(0, 0, 0, 0, 0));
    cyc(0, 0, 0, ex(0, 0, 0, 0, 0));
    bus.lo_lim = 3'd2; bus.hi_lim = 3'd5;
    cyc(1, 1, 0, ex(0, 1, 0, 0, 0));   // count 0 -> SEEK
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 1
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 2 -> RUN_UP
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 3
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 4
    cyc(1, 0, 0, ex(1, 1, 1, 0, 1));   // 5 reverse
    cyc(1, 0, 0, ex(1, 1, 0, 0, 1));   // 4
    cyc(1, 0, 0, ex(1, 1, 0, 0, 1));   // 3
    cyc(1, 0, 0, ex(0, 1, 1, 0, 2));   // 2 reverse
    cyc(1, 0, 0, ex(0, 1, 0, 0, 2));   // 3
    cyc(1, 0, 1, ex(0, 0, 0, 0, 2));   // 4 stop

    // rejected start
    bus.lo_lim = 3'd4; bus.hi_lim = 3'd4;
    cyc(1, 1, 0, ex(0, 0, 0, 1, 2));
    cyc(1, 0, 0, ex(0, 0, 0, 0, 2));

    // wrap during seek: count 7, lo=1 hi=3
    bus.lo_lim = 3'd1; bus.hi_lim = 3'd3;
    cyc(1, 1, 0, ex(0, 1, 0, 0, 0));   // 7 -> SEEK
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 0
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 1 -> RUN_UP
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 2
    cyc(1, 0, 0, ex(1, 1, 1, 0, 1));   // 3 reverse
    cyc(1, 0, 0, ex(1, 1, 0, 0, 1));   // 2
    cyc(1, 0, 0, ex(0, 1, 1, 0, 2));   // 1 reverse
    cyc(1, 0, 1, ex(0, 0, 0, 0, 2));   // 2 stop

    // adjacent limits 6/7, also drives bounce_cnt into saturation
    bus.lo_lim = 3'd6; bus.hi_lim = 3'd7;
    cyc(1, 1, 0, ex(0, 1, 0, 0, 0));   // 3 -> SEEK
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 4
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 5
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 6 -> RUN_UP
    cyc(1, 0, 0, ex(1, 1, 1, 0, 1));   // 7
    cyc(1, 0, 0, ex(0, 1, 1, 0, 2));   // 6
    cyc(1, 0, 0, ex(1, 1, 1, 0, 3));   // 7
    cyc(1, 0, 0, ex(0, 1, 1, 0, 3));   // 6 saturated
    cyc(1, 0, 0, ex(1, 1, 1, 0, 3));   // 7
    cyc(1, 0, 1, ex(0, 0, 0, 0, 3));   // 6 stop

    // disturbance in RUN_UP, recovery, then stop together with start
    bus.lo_lim = 3'd2; bus.hi_lim = 3'd5;
    cyc(1, 1, 0, ex(0, 1, 0, 0, 0));   // 7 -> SEEK
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 0
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 1
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 2 -> RUN_UP
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 3
    cnt = 3'd0;                         // external clear of the counter
    cyc(1, 0, 0, ex(0, 1, 0, 1, 0));   // 0 out of range -> SEEK
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 1
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 2 -> RUN_UP
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 3
    cyc(1, 0, 0, ex(0, 1, 0, 0, 0));   // 4
    cyc(1, 0, 0, ex(1, 1, 1, 0, 1));   // 5 reverse
    cyc(1, 1, 1, ex(0, 0, 0, 0, 1));   // stop wins, count kept
    cyc(1, 0, 0, ex(0, 0, 0, 0, 1));

    // direct IDLE -> RUN_UP, then reset mid-run
    bus.lo_lim = 3'd6; bus.hi_lim = 3'd7;
    cyc(1, 1, 0, ex(0, 1, 0, 0, 0));   // 6 -> RUN_UP
    cyc(1, 0, 0, ex(1, 1, 1, 0, 1));   // 7
    cyc(1, 0, 0, ex(0, 1, 1, 0, 2));   // 6
    cyc(0, 1, 0, ex(0, 0, 0, 0, 0));   // reset beats start
    cyc(1, 0, 0, ex(0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
